// File: rtl/ps2_direction_decoder_if.sv
// rtl/ps2_direction_decoder_if.sv - received PS/2 byte stream into the direction decoder
interface ps2_direction_decoder_if;
    logic [7:0] byte_in;
    logic       byte_valid;

    modport master (output byte_in, output byte_valid);
    modport slave  (input  byte_in, input  byte_valid);
endinterface

// File: rtl/ps2_direction_decoder.sv
// rtl/ps2_direction_decoder.sv - PS/2 scan-code to WASD/arrow direction decoder
module ps2_direction_decoder #(
    parameter int TIMEOUT = 50000
) (
    input  logic                    clock,
    input  logic                    reset,
    ps2_direction_decoder_if.slave  rx,
    output logic                    up,
    output logic                    down,
    output logic                    left,
    output logic                    right,
    output logic                    press_pulse,
    output logic [1:0]              press_dir
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t        state, state_next;
    logic [7:0]    held, held_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [CW:0]   cnt_inc;
    logic          timeout_hit;
    logic          wasd_hit, arrow_hit;
    logic [1:0]    wasd_idx, arrow_idx;
    logic [3:0]    dir_q, dir_next, rise;
    logic [1:0]    rise_dir;

    always_comb begin
        wasd_hit = 1'b1;
        wasd_idx = 2'd0;
        case (rx.byte_in)
            8'h1D:   wasd_idx = 2'd0;
            8'h1B:   wasd_idx = 2'd1;
            8'h1C:   wasd_idx = 2'd2;
            8'h23:   wasd_idx = 2'd3;
            default: wasd_hit = 1'b0;
        endcase
        arrow_hit = 1'b1;
        arrow_idx = 2'd0;
        case (rx.byte_in)
            8'h75:   arrow_idx = 2'd0;
            8'h72:   arrow_idx = 2'd1;
            8'h6B:   arrow_idx = 2'd2;
            8'h74:   arrow_idx = 2'd3;
            default: arrow_hit = 1'b0;
        endcase
    end

    // Timeout fires on the edge where the count would reach TIMEOUT-1.
    assign cnt_inc     = {1'b0, cnt} + (CW+1)'(1);
    assign timeout_hit = (state != IDLE) && (cnt_inc >= (CW+1)'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        held_next  = held;
        if (rx.byte_valid) begin
            if (rx.byte_in == 8'h00 || rx.byte_in == 8'hFF) begin
                held_next  = 8'h00;
                state_next = IDLE;
            end else if (rx.byte_in == 8'hE1) begin
                state_next = state;
            end else if (rx.byte_in == 8'hE0) begin
                state_next = EXT;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx.byte_in == 8'hF0) state_next = BRK;
                        else if (wasd_hit)       held_next[{1'b0, wasd_idx}] = 1'b1;
                    end
                    EXT: begin
                        state_next = IDLE;
                        if (rx.byte_in == 8'hF0) state_next = EXT_BRK;
                        else if (arrow_hit)      held_next[{1'b1, arrow_idx}] = 1'b1;
                    end
                    BRK: begin
                        state_next = IDLE;
                        if (rx.byte_in == 8'hF0) state_next = BRK;
                        else if (wasd_hit)       held_next[{1'b0, wasd_idx}] = 1'b0;
                    end
                    default: begin
                        state_next = IDLE;
                        if (rx.byte_in == 8'hF0) state_next = EXT_BRK;
                        else if (arrow_hit)      held_next[{1'b1, arrow_idx}] = 1'b0;
                    end
                endcase
            end
        end else if (timeout_hit) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        cnt_next = cnt_inc[CW-1:0];
        if (rx.byte_valid || state == IDLE || timeout_hit)
            cnt_next = '0;
    end

    // Direction order in the 4-bit vectors: [0]=up [1]=down [2]=left [3]=right.
    always_comb begin
        dir_next = held_next[3:0] | held_next[7:4];
        rise     = dir_next & ~dir_q;
        rise_dir = 2'd0;
        if (rise[0])      rise_dir = 2'd0;
        else if (rise[1]) rise_dir = 2'd1;
        else if (rise[2]) rise_dir = 2'd2;
        else if (rise[3]) rise_dir = 2'd3;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            held        <= 8'h00;
            cnt         <= '0;
            dir_q       <= 4'h0;
            press_pulse <= 1'b0;
            press_dir   <= 2'd0;
        end else begin
            state       <= state_next;
            held        <= held_next;
            cnt         <= cnt_next;
            dir_q       <= dir_next;
            press_pulse <= |rise;
            if (|rise)
                press_dir <= rise_dir;
        end
    end

    assign up    = dir_q[0];
    assign down  = dir_q[1];
    assign left  = dir_q[2];
    assign right = dir_q[3];
endmodule

// File: doc/ps2_direction_decoder.md
PS2_DIRECTION_DECODER -- requirements
Module: ps2_direction_decoder

Interface
REQ-001 Parameter TIMEOUT, default 50000, is the number of idle clock cycles after which a partial prefix sequence is abandoned.
REQ-002 Port clock, input, 1 bit: single system clock; every register SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: reset is synchronous and active-low.
REQ-004 Port byte_in, input, 8 bits: received PS/2 scan-code byte, valid only while byte_valid=1.
REQ-005 Port byte_valid, input, 1 bit: one-cycle strobe per received byte.
REQ-006 Ports up, down, left, right, each output 1 bit: registered level, high while the mapped key is held.
REQ-007 Port press_pulse, output, 1 bit: one-cycle strobe on a new direction press.
REQ-008 Port press_dir, output, 2 bits: direction of the latest press (00 up, 01 down, 10 left, 11 right), held between pulses.

Function
REQ-009 Key map: make 1D->up, 1B->down, 1C->left, 23->right (WASD); E0 75->up, E0 72->down, E0 6B->left, E0 74->right (arrows).
REQ-010 Eight internal held bits SHALL exist, one per mapped key; each direction output SHALL be the OR of its WASD bit and arrow bit.
REQ-011 FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
REQ-012 IDLE transitions: E0 -> EXT; F0 -> BRK; mapped code -> set held bit, stay IDLE; any other byte -> stay IDLE.
REQ-013 EXT transitions: F0 -> EXT_BRK; mapped arrow code -> set held bit, go IDLE; any other byte -> IDLE.
REQ-014 BRK transitions: mapped WASD code -> clear held bit, go IDLE; any other byte -> IDLE.
REQ-015 EXT_BRK transitions: mapped arrow code -> clear held bit, go IDLE; any other byte -> IDLE.
REQ-016 E0 received in BRK, EXT or EXT_BRK SHALL go to EXT; F0 received in BRK or EXT_BRK SHALL stay in the current state.
REQ-017 Byte E1 SHALL be ignored in every state, with no state change.
REQ-018 Byte 00 or FF (keyboard error/overrun) in any state SHALL clear all eight held bits and go IDLE.
REQ-019 The FSM SHALL advance only on cycles where byte_valid=1; byte_in SHALL be ignored otherwise.
REQ-020 Latency: held outputs, press_pulse and press_dir SHALL update on the clock edge that samples the completing byte_valid, so they are visible in the following cycle.
REQ-021 press_pulse SHALL fire only when a direction output goes 0->1; a typematic repeat or the second key of the same direction SHALL NOT pulse.
REQ-022 press_dir SHALL load the newly pressed direction together with press_pulse.
REQ-023 Releasing one key of a direction while its other key is held SHALL keep that direction high.
REQ-024 Timeout counter: SHALL be cleared on every byte_valid and while in IDLE, and SHALL increment every cycle in any other state.
REQ-025 When the counter reaches TIMEOUT-1 with no byte_valid, the FSM SHALL go to IDLE and held bits SHALL be unchanged.
REQ-026 The timeout counter width SHALL be the minimum required to hold TIMEOUT-1.
REQ-027 Multiple directions MAY be high simultaneously; no priority resolution SHALL be applied in this block.

Reset
REQ-028 With reset=0 at a rising edge, the block SHALL set: FSM=IDLE, all held bits=0, up/down/left/right=0, press_pulse=0, press_dir=00, timeout counter=0.
REQ-029 Reset SHALL override byte_valid in the same cycle, and a reset mid-sequence (for example after E0) SHALL discard the prefix.

Verification
REQ-030 Bytes 1D; then F0 1D -> up=1 and press_pulse=1 for one cycle with press_dir=00 after the first byte; up=0 and no pulse after the release.
REQ-031 Bytes E0 74, then E0 74 repeated three times -> right=1, exactly one press_pulse with press_dir=11; E0 F0 74 -> right=0.
REQ-032 Bytes 1C, then E0 6B, then F0 1C -> left=1 throughout, exactly one pulse; E0 F0 6B -> left=0.
REQ-033 Byte E0, then 49999 idle cycles, then 1D -> FSM in IDLE on arrival of 1D, up=1 (WASD decode, not arrow).
REQ-034 Hold 1D and 23, send FF -> up=0 and right=0 next cycle; reset=0 asserted after E0 in the same cycle as byte_valid with byte 75 -> all outputs 0, FSM=IDLE.
